// File: rtl/instr_encoder.sv
// Sequential MIPS instruction encoder and program loader: packs symbolic instructions
// into 32-bit words and writes them to consecutive instruction-memory addresses from 0.
module instr_encoder #(
   parameter int unsigned n     = 32,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [2:0]    in_kind,
   input  logic [4:0]    in_rs,
   input  logic [4:0]    in_rt,
   input  logic [4:0]    in_rd,
   input  logic [4:0]    in_shamt,
   input  logic [5:0]    in_funct,
   input  logic [15:0]   in_imm,
   input  logic [25:0]   in_target,
   input  logic          in_last,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [n-1:0]  imem_wdata,
   output logic [AW:0]   count,
   output logic          done,
   output logic          error
);

   localparam logic [2:0] KindRtype = 3'd0;
   localparam logic [2:0] KindLw    = 3'd1;
   localparam logic [2:0] KindSw    = 3'd2;
   localparam logic [2:0] KindBeq   = 3'd3;
   localparam logic [2:0] KindAddi  = 3'd4;
   localparam logic [2:0] KindJ     = 3'd5;

   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StWrite, StDone, StErr} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   count_q, count_d;
   logic [n-1:0]  word_q, word_d;
   logic          last_q, last_d;

   logic          legal;
   logic [31:0]   enc_word;

   // Opcode packing; fields a kind does not use are simply not wired in.
   always_comb begin
      legal    = 1'b1;
      enc_word = '0;
      case (in_kind)
         KindRtype: enc_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
         KindLw:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
         KindSw:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
         KindBeq:   enc_word = {6'b000100, in_rs, in_rt, in_imm};
         KindAddi:  enc_word = {6'b001000, in_rs, in_rt, in_imm};
         KindJ:     enc_word = {6'b000010, in_target};
         default:   legal    = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      word_d  = word_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle, StDone, StErr: begin
            if (start) begin
               state_d = StLoad;
               addr_d  = '0;
               count_d = '0;
            end
         end
         StLoad: begin
            if (in_valid) begin
               if (legal) begin
                  word_d  = enc_word;
                  last_d  = in_last;
                  state_d = StWrite;
               end else begin
                  state_d = StErr;
               end
            end
         end
         StWrite: begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
            // A last word on the top address still ends the session normally.
            if (last_q) begin
               state_d = StDone;
            end else if (addr_q == LastAddr) begin
               state_d = StErr;
            end else begin
               state_d = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         count_q <= '0;
         word_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         word_q  <= word_d;
         last_q  <= last_d;
      end
   end

   assign in_ready   = (state_q == StLoad);
   assign imem_we    = (state_q == StWrite);
   assign imem_addr  = addr_q;
   assign imem_wdata = word_q;
   assign count      = count_q;
   assign done       = (state_q == StDone);
   assign error      = (state_q == StErr);

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder and program loader: the inverse of the controller's main decoder. It accepts symbolic instructions (kind plus fields) over a valid/ready handshake, packs each into a 32-bit MIPS word with the correct opcode, and writes the words to consecutive instruction-memory addresses starting at 0. It sits between the testbench/boot source and the single-cycle CPU's instruction memory. It also reports completion, word count and errors.

## Interface
- n, 32, instruction word width; fixed at 32
- DEPTH, 64, instruction-memory depth in words
- AW, 6, address width; must satisfy 2**AW == DEPTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  begin a load session; one-cycle pulse
- in_valid  input  1  input instruction is valid
- in_ready  output  1  encoder can accept an instruction
- in_kind  input  3  0=RTYPE, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6-7 illegal
- in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift fields
- in_funct  input  6  R-type funct field
- in_imm  input  16  immediate or branch offset, passed raw
- in_target  input  26  jump target field
- in_last  input  1  marks the final instruction of the program
- imem_we  output  1  instruction-memory write strobe
- imem_addr  output  AW  word address
- imem_wdata  output  n  encoded instruction
- count  output  AW+1  number of words written in the current session
- done  output  1  session ended normally
- error  output  1  session aborted

## Operation
- States: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - in_ready=0.
  - start -> LOAD; addr=0, count=0.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready with a legal kind: register the encoded word, then go to WRITE.
  - On an illegal kind (6/7): go to ERR; nothing is written.
  - start is ignored.
- Encoding, MSB first:
  - RTYPE: {6'b000000, rs, rt, rd, shamt, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - ADDI: {6'b001000, rs, rt, imm}
  - J: {6'b000010, target}
  - Fields that a kind does not use are ignored.
- WRITE:
  - imem_we=1 for exactly one cycle, with imem_addr=addr and the registered word on imem_wdata.
  - in_ready=0.
  - On leaving WRITE: addr increments and count increments.
  - If the word carried in_last -> DONE.
  - Else if the word just written used addr=DEPTH-1 -> ERR (memory full, no wrap-around).
  - Else -> LOAD.
  - in_last on address DEPTH-1 -> DONE, not ERR.
- DONE:
  - done=1; count holds.
  - start -> LOAD and clears addr, count and done.
- ERR:
  - error=1; count holds the number of words already written.
  - start -> LOAD and clears error, addr and count.
- Reset (asynchronous, any time, including mid-WRITE):
  - state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, error=0.
  - A write in progress is dropped.

## Timing
- Outputs are registered; in_ready is decoded from state only (no combinational path from in_valid).
- Handshake at cycle t -> imem_we high at cycle t+1; in_ready returns high at t+2.
- Throughput is one instruction every 2 cycles.
- count updates in the cycle after imem_we.
- done and error assert in the cycle after the final WRITE or the illegal handshake, and stay high until start or reset.
- in_valid without in_ready has no effect. A source may hold in_valid high continuously.

## Test plan
- Reset: assert rst_n=0 mid-WRITE -> all outputs 0 immediately, state IDLE, no further imem_we.
- Single-instruction session: start, then RTYPE rs=1 rt=2 rd=3 shamt=0 funct=6'b100000 with last -> one write of 0x00221820 at addr 0, count=1, done=1.
- Six-instruction program:
  - Sequence: LW rs=1 rt=2 imm=4; SW imm=8; BEQ imm=16'hFFFF; ADDI rs=0 rt=5 imm=7; J target=26'h10; add with last.
  - Required writes: 0x8C220004, 0xAC220008, 0x1022FFFF, 0x20050007, 0x08000010, 0x00221820 at addresses 0-5.
  - Required end state: count=6, done=1.
- Illegal kind: third input has kind=7 -> addresses 0-1 written, no third write, error=1, count=2. A following start clears error and restarts writes at addr 0.
- Full boundary, DEPTH=64:
  - 64 instructions without last -> 64th written at addr 63, then error=1, count=64.
  - Repeat with last on the 64th -> done=1, error=0.
- Backpressure: hold in_valid=1 continuously -> imem_we pulses every 2nd cycle, never in consecutive cycles. start pulsed during LOAD -> ignored.
